// File: rtl/buf_seq_pkg.sv
// Shared types and constants for the shift-buffer sequencer.
package buf_seq_pkg;
   localparam int DEPTH  = 16;
   localparam int WORD_W = 32;
   localparam int WIN    = 4;
   localparam int ADDR_W = 6;
   localparam int PASS_W = 8;

   localparam int NUM_WIN     = DEPTH / WIN;
   localparam int REFILL_BASE = DEPTH - WIN;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      READ,
      SHIFT,
      REFILL,
      DONE
   } state_t;
endpackage

// File: rtl/buf_seq_ctrl_ptr.sv
// Loadable incrementing pointer with a compare against its terminal value.
module buf_seq_ptr #(
   parameter int W    = 6,
   parameter int STEP = 1,
   parameter int TERM = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   output logic [W-1:0] ptr,
   output logic         at_term
);
   always_ff @(posedge clk) begin
      if (rst)       ptr <= '0;
      else if (load) ptr <= load_val;
      else if (inc)  ptr <= ptr + W'(STEP);
   end

   assign at_term = (ptr == W'(TERM));
endmodule

// File: rtl/buf_seq_ctrl.sv
// Fill / read / shift / refill sequencer for the 16x32 shift buffer.
// Optional stall_cycles counter is built when BUF_SEQ_STALL_CNT_EN is defined.
module buf_seq_ctrl
   import buf_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [PASS_W-1:0] num_shifts,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              buf_we,
   output logic [ADDR_W-1:0] buf_addr,
   output logic [WORD_W-1:0] buf_data,
   output logic              buf_shift_up,
   output logic              win_valid,
   input  logic              win_ready,
   output logic              win_last,
   output logic              busy,
   output logic              done
`ifdef BUF_SEQ_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);
   state_t            state, next_state;
   logic [PASS_W-1:0] num_q, pass_cnt;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              wr_term, rd_term;
   logic              in_fill, accept, win_hs, final_pass, job_start;

   assign in_fill    = (state == FILL) || (state == REFILL);
   assign accept     = in_fill && in_valid;
   assign win_hs     = (state == READ) && win_ready;
   assign final_pass = (pass_cnt == num_q);
   assign job_start  = (state == IDLE) && start;

   // Terminal accepts/handshakes reload instead of stepping, so pointers stay below DEPTH.
   buf_seq_ptr #(.W(ADDR_W), .STEP(1), .TERM(DEPTH - 1)) u_wr_ptr (
      .clk      (clk),
      .rst      (rst),
      .load     (job_start || (state == SHIFT)),
      .load_val ((state == SHIFT) ? ADDR_W'(REFILL_BASE) : '0),
      .inc      (accept && !wr_term),
      .ptr      (wr_ptr),
      .at_term  (wr_term)
   );

   buf_seq_ptr #(.W(ADDR_W), .STEP(WIN), .TERM(REFILL_BASE)) u_rd_ptr (
      .clk      (clk),
      .rst      (rst),
      .load     ((accept && wr_term) || (win_hs && rd_term)),
      .load_val ('0),
      .inc      (win_hs && !rd_term),
      .ptr      (rd_ptr),
      .at_term  (rd_term)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         num_q    <= '0;
         pass_cnt <= '0;
      end else begin
         state <= next_state;
         if (job_start) begin
            num_q    <= num_shifts;
            pass_cnt <= '0;
         end else if (state == SHIFT) begin
            pass_cnt <= pass_cnt + PASS_W'(1);
         end
      end
   end

   always_comb begin
      next_state   = state;
      in_ready     = 1'b0;
      buf_we       = 1'b0;
      buf_addr     = '0;
      buf_data     = '0;
      buf_shift_up = 1'b0;
      win_valid    = 1'b0;
      win_last     = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) next_state = FILL;
         end
         FILL, REFILL: begin
            in_ready = 1'b1;
            buf_we   = in_valid;
            buf_addr = wr_ptr;
            buf_data = in_data;
            if (in_valid && wr_term) next_state = READ;
         end
         READ: begin
            win_valid = 1'b1;
            buf_addr  = rd_ptr;
            buf_data  = in_data;
            win_last  = rd_term && final_pass;
            if (win_ready && rd_term) next_state = final_pass ? DONE : SHIFT;
         end
         SHIFT: begin
            buf_shift_up = 1'b1;
            next_state   = REFILL;
         end
         DONE: begin
            busy       = 1'b0;
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            busy       = 1'b0;
            next_state = IDLE;
         end
      endcase
   end

`ifdef BUF_SEQ_STALL_CNT_EN
   logic stall;
   assign stall = ((state == READ) && !win_ready) || (in_fill && !in_valid);

   always_ff @(posedge clk) begin
      if (rst || job_start)                stall_cycles <= '0;
      else if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
   end
`endif
endmodule

// File: tb/tb_buf_seq_ctrl.sv
// Bench for buf_seq_ctrl: a job-level event list (writes, windows, shifts, done)
// is planned from num_shifts and compared against what the controller emits.
module tb_buf_seq_ctrl;
   import buf_seq_pkg::*;

   localparam logic [1:0] K_WR = 2'd0, K_WIN = 2'd1, K_SH = 2'd2, K_DONE = 2'd3;

   logic              clk, rst, start;
   logic [PASS_W-1:0] num_shifts;
   logic              in_valid, in_ready;
   logic [WORD_W-1:0] in_data;
   logic              buf_we;
   logic [ADDR_W-1:0] buf_addr;
   logic [WORD_W-1:0] buf_data;
   logic              buf_shift_up, win_valid, win_ready, win_last, busy, done;
`ifdef BUF_SEQ_STALL_CNT_EN
   logic [31:0]       stall_cycles;
`endif

   buf_seq_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .num_shifts   (num_shifts),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .buf_we       (buf_we),
      .buf_addr     (buf_addr),
      .buf_data     (buf_data),
      .buf_shift_up (buf_shift_up),
      .win_valid    (win_valid),
      .win_ready    (win_ready),
      .win_last     (win_last),
      .busy         (busy),
      .done         (done)
`ifdef BUF_SEQ_STALL_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [40:0] exp_q[$];
   logic [31:0] src_q[$];
   bit mon_en = 0, rand_mode = 0, force_iv = 0, force_wr = 0;
   int exp_stall = -1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [40:0] ev(input logic [1:0] k, input logic l,
                                      input logic [5:0] a, input logic [31:0] d);
      return {k, l, a, d};
   endfunction

   // Job plan: fill all words, then per pass NUM_WIN windows, with shift+refill between passes.
   task automatic plan(input int n, input bit pat);
      logic [31:0] w;
      for (int i = 0; i < DEPTH; i++) begin
         w = pat ? 32'(i) : $urandom;
         src_q.push_back(w);
         exp_q.push_back(ev(K_WR, 1'b0, 6'(i), w));
      end
      for (int p = 0; p <= n; p++) begin
         for (int k = 0; k < NUM_WIN; k++)
            exp_q.push_back(ev(K_WIN, (p == n) && (k == NUM_WIN - 1), 6'(k * WIN), 32'd0));
         if (p < n) begin
            exp_q.push_back(ev(K_SH, 1'b0, 6'd0, 32'd0));
            for (int i = 0; i < WIN; i++) begin
               w = pat ? 32'(32'hA0 + 16 * p + i) : $urandom;
               src_q.push_back(w);
               exp_q.push_back(ev(K_WR, 1'b0, 6'(DEPTH - WIN + i), w));
            end
         end
      end
      exp_q.push_back(ev(K_DONE, 1'b0, 6'd0, 32'd0));
   endtask

   // Drivers update just after the rising edge.
   always @(posedge clk) begin
      #1;
      if (rand_mode) begin
         in_valid  = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
         win_ready = ($urandom_range(0, 3) != 0);
      end else begin
         in_valid  = (src_q.size() > 0) && !force_iv;
         win_ready = !force_wr;
      end
      in_data = (src_q.size() > 0) ? src_q[0] : $urandom;
   end

   // Monitor / scoreboard on the falling edge.
   logic              prev_wv = 0, prev_wr = 0, prev_ir = 0, prev_iv = 0, prev_hs_last = 0;
   logic [ADDR_W-1:0] prev_addr = '0;
   always @(negedge clk) begin
      logic [40:0] obs;
      logic [40:0] e;
      logic        has_ev;
      if (mon_en) begin
         chk("exclusive", 64'($countones({buf_we, buf_shift_up, win_valid}) <= 1), 64'd1);
         chk("busy", 64'(busy), 64'((exp_q.size() != 0) && (exp_q[0][40:39] != K_DONE)));
         if (!in_ready && !win_valid) begin
            chk("idle_addr", 64'(buf_addr), 64'd0);
            chk("idle_data", 64'(buf_data), 64'd0);
         end
         if (!win_valid) chk("last_off", 64'(win_last), 64'd0);
         if (prev_wv && !prev_wr) begin
            chk("hold_win_valid", 64'(win_valid), 64'd1);
            chk("hold_win_addr", 64'(buf_addr), 64'(prev_addr));
         end
         if (prev_ir && !prev_iv) begin
            chk("hold_in_ready", 64'(in_ready), 64'd1);
            chk("hold_wr_addr", 64'(buf_addr), 64'(prev_addr));
         end
         has_ev = 1'b1;
         obs    = '0;
         if (buf_we) obs = ev(K_WR, 1'b0, buf_addr, buf_data);
         else if (win_valid && win_ready) obs = ev(K_WIN, win_last, buf_addr, 32'd0);
         else if (buf_shift_up) obs = ev(K_SH, 1'b0, 6'd0, 32'd0);
         else if (done) begin
            obs = ev(K_DONE, 1'b0, 6'd0, 32'd0);
            chk("done_after_last", 64'(prev_hs_last), 64'd1);
`ifdef BUF_SEQ_STALL_CNT_EN
            if (exp_stall >= 0) chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
`endif
         end else has_ev = 1'b0;
         if (has_ev) begin
            chk("event_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("event", 64'(obs), 64'(e));
            end
         end
      end
      prev_wv      = win_valid;
      prev_wr      = win_ready;
      prev_ir      = in_ready;
      prev_iv      = in_valid;
      prev_addr    = buf_addr;
      prev_hs_last = win_valid && win_ready && win_last;
      if (in_valid && in_ready && src_q.size() > 0) void'(src_q.pop_front());
   end

   task automatic start_job(input int n, input bit pat);
      @(posedge clk);
      #2;
      num_shifts = PASS_W'(n);
      start      = 1'b1;
      @(posedge clk);
      plan(n, pat);
      #2;
      start = 1'b0;
   endtask

   task automatic wait_job(input int budget, input bit rnd_start);
      int t = 0;
      while (exp_q.size() != 0 && t < budget) begin
         @(posedge clk);
         #2;
         t++;
         if (rnd_start && exp_q.size() != 0 && $urandom_range(0, 30) == 0) begin
            start      = 1'b1;
            num_shifts = PASS_W'($urandom);
            @(posedge clk);
            #2;
            start = 1'b0;
            t++;
         end
      end
      chk("job_complete", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_buf_we"}, 64'(buf_we), 64'd0);
      chk({tag, "_buf_addr"}, 64'(buf_addr), 64'd0);
      chk({tag, "_buf_data"}, 64'(buf_data), 64'd0);
      chk({tag, "_shift"}, 64'(buf_shift_up), 64'd0);
      chk({tag, "_win_valid"}, 64'(win_valid), 64'd0);
      chk({tag, "_win_last"}, 64'(win_last), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
`ifdef BUF_SEQ_STALL_CNT_EN
      chk({tag, "_stall"}, 64'(stall_cycles), 64'd0);
`endif
   endtask

   initial begin
      int t;
      rst = 1'b1; start = 1'b0; num_shifts = '0;
      in_valid = 1'b0; in_data = '0; win_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_all_zero("reset");
      rst    = 1'b0;
      mon_en = 1;

      // Single pass, sequential data, full throughput.
      start_job(0, 1);
      wait_job(500, 0);

      // Three passes with A0.., B0.. refills.
      start_job(2, 1);
      wait_job(500, 0);

      // Input gap at wr_ptr=7 with an ignored start, then a window stall at addr 4.
      exp_stall = 8;
      start_job(0, 1);
      t = 0;
      do begin @(negedge clk); #2; t++; end while (!(buf_we && buf_addr == 6) && t < 200);
      chk("reach_wr6", 64'(t < 200), 64'd1);
      force_iv = 1;
      @(posedge clk);
      @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      @(posedge clk);
      force_iv = 0;
      t = 0;
      do begin @(negedge clk); #2; t++; end while (!(win_valid && buf_addr == 0) && t < 200);
      chk("reach_win0", 64'(t < 200), 64'd1);
      force_wr = 1;
      repeat (6) @(posedge clk);
      force_wr = 0;
      wait_job(500, 0);
      exp_stall = -1;

      // Abort with rst during a refill at wr_ptr=13.
      start_job(1, 1);
      t = 0;
      do begin @(negedge clk); #2; t++; end while (!buf_shift_up && t < 300);
      chk("reach_shift", 64'(t < 300), 64'd1);
      t = 0;
      do begin @(negedge clk); #2; t++; end while (!(buf_we && buf_addr == 13) && t < 300);
      chk("reach_refill13", 64'(t < 300), 64'd1);
      mon_en = 0;
      rst    = 1'b1;
      @(posedge clk);
      #2;
      check_all_zero("abort");
      exp_q.delete();
      src_q.delete();
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", 64'(done), 64'd0);
      end
      mon_en = 1;
      start_job(1, 0);
      wait_job(500, 0);

      // Randomized throttling, pass counts and stray start pulses.
      rand_mode = 1;
      for (int j = 0; j < 10; j++) begin
         start_job($urandom_range(0, 3), 0);
         wait_job(3000, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
